// File: rtl/counter_param_if.sv
// ============================================================================
// Module   : counter_param_if
// Brief    : Control/status bundle for the parametrised up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_param_if #(
    parameter int WIDTH = 12
);
    logic             load;
    logic             enable;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] counter;
    logic             wrap;
    logic             ovf;
    logic             zero;
    logic             at_limit;

    modport master (
        output load, enable, up, sat, step, limit, data,
        input  counter, wrap, ovf, zero, at_limit
    );

    modport slave (
        input  load, enable, up, sat, step, limit, data,
        output counter, wrap, ovf, zero, at_limit
    );
endinterface

`default_nettype wire

// File: rtl/counter_param.sv
// ============================================================================
// Module   : counter_param
// Brief    : Up/down counter with programmable step, inclusive limit,
//            wrap/saturate boundary handling and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_param #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire              clk,
    input  wire              reset,
    counter_param_if.slave   bus
);

    localparam int C_W1 = WIDTH + 1;

    logic [WIDTH-1:0] r_counter;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_s;
    logic [C_W1-1:0]  w_cnt_x;
    logic [C_W1-1:0]  w_lim_x;
    logic [C_W1-1:0]  w_mod_x;
    logic [C_W1-1:0]  w_s_x;
    logic [C_W1-1:0]  w_sum_x;
    logic [C_W1-1:0]  w_dwrap_x;
    logic [C_W1-1:0]  w_uwrap_x;
    logic             w_out_of_range;
    logic [WIDTH-1:0] w_next;
    logic             w_next_wrap;

    // Step larger than the range would skip whole periods; clamp it to limit.
    assign w_s       = (bus.step > bus.limit) ? bus.limit : bus.step;

    assign w_cnt_x   = {1'b0, r_counter};
    assign w_lim_x   = {1'b0, bus.limit};
    assign w_s_x     = {1'b0, w_s};
    assign w_mod_x   = w_lim_x + {{WIDTH{1'b0}}, 1'b1};
    assign w_sum_x   = w_cnt_x + w_s_x;
    assign w_uwrap_x = w_sum_x - w_mod_x;
    assign w_dwrap_x = w_cnt_x + w_mod_x - w_s_x;

    assign w_out_of_range = (r_counter > bus.limit);

    always_comb begin
        w_next      = r_counter;
        w_next_wrap = 1'b0;
        if (w_out_of_range) begin
            // Only reachable after limit was lowered below the current count.
            w_next      = bus.up ? '0 : bus.limit;
            w_next_wrap = 1'b1;
        end else if (bus.up) begin
            if (w_sum_x > w_lim_x) begin
                w_next      = bus.sat ? bus.limit : w_uwrap_x[WIDTH-1:0];
                w_next_wrap = 1'b1;
            end else begin
                w_next = w_sum_x[WIDTH-1:0];
            end
        end else begin
            if (r_counter >= w_s) begin
                w_next = r_counter - w_s;
            end else begin
                w_next      = bus.sat ? '0 : w_dwrap_x[WIDTH-1:0];
                w_next_wrap = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= RESET_VAL;
            r_wrap    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.load) begin
            r_counter <= (bus.data > bus.limit) ? bus.limit : bus.data;
            r_wrap    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.enable) begin
            r_counter <= w_next;
            r_wrap    <= w_next_wrap;
            r_ovf     <= r_ovf | w_next_wrap;
        end else begin
            r_wrap    <= 1'b0;
        end
    end

    assign bus.counter  = r_counter;
    assign bus.wrap     = r_wrap;
    assign bus.ovf      = r_ovf;
    assign bus.zero     = (r_counter == '0);
    assign bus.at_limit = (r_counter == bus.limit);

endmodule

`default_nettype wire

// File: tb/tb_counter_param.sv
// ============================================================================
// Module   : tb_counter_param
// Brief    : Directed-vector bench for counter_param (WIDTH=12, RESET_VAL=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_param;

    localparam int C_W = 12;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    counter_param_if #(.WIDTH(C_W)) bus ();

    counter_param #(
        .WIDTH     (C_W),
        .RESET_VAL (12'h000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [11:0] c,
                             input logic w, input logic o);
        chk({tag, ".counter"}, {20'd0, bus.counter}, {20'd0, c});
        chk({tag, ".wrap"},    {31'd0, bus.wrap},    {31'd0, w});
        chk({tag, ".ovf"},     {31'd0, bus.ovf},     {31'd0, o});
    endtask

    task automatic do_load(input logic [11:0] lim, input logic [11:0] d);
        bus.limit  = lim;
        bus.data   = d;
        bus.load   = 1'b1;
        bus.enable = 1'b0;
        tick();
        bus.load   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset      = 1'b1;
        bus.load   = 1'b1;
        bus.enable = 1'b1;
        bus.up     = 1'b1;
        bus.sat    = 1'b0;
        bus.step   = 12'd1;
        bus.limit  = 12'hFFF;
        bus.data   = 12'hABC;

        // Reset dominates load and enable
        tick();
        tick();
        chk_state("rst", 12'h000, 1'b0, 1'b0);
        chk("rst.zero", {31'd0, bus.zero}, 32'd1);
        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.enable = 1'b0;

        // Up wrap at full range
        do_load(12'hFFF, 12'hFFE);
        chk_state("upw0", 12'hFFE, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick();
        chk_state("upw1", 12'hFFF, 1'b0, 1'b0);
        chk("upw1.at_limit", {31'd0, bus.at_limit}, 32'd1);
        tick();
        chk_state("upw2", 12'h000, 1'b1, 1'b1);
        chk("upw2.zero", {31'd0, bus.zero}, 32'd1);
        tick();
        chk_state("upw3", 12'h001, 1'b0, 1'b1);

        // Load beats enable and clears ovf; load clamps to limit
        bus.data = 12'h0F7;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_state("ldv", 12'h0F7, 1'b0, 1'b0);
        do_load(12'h010, 12'h020);
        chk_state("ldclamp", 12'h010, 1'b0, 1'b0);
        chk("ldclamp.at_limit", {31'd0, bus.at_limit}, 32'd1);

        // Modulo down wrap, then hold
        do_load(12'd9, 12'd1);
        bus.up = 1'b0; bus.sat = 1'b0; bus.step = 12'd3; bus.enable = 1'b1;
        tick();
        chk_state("dnw0", 12'd8, 1'b1, 1'b1);
        tick();
        chk_state("dnw1", 12'd5, 1'b0, 1'b1);
        bus.enable = 1'b0;
        tick();
        chk_state("hold", 12'd5, 1'b0, 1'b1);

        // Saturate up, repeated pinned count pulses wrap again
        do_load(12'h00F, 12'h00C);
        bus.up = 1'b1; bus.sat = 1'b1; bus.step = 12'd4; bus.enable = 1'b1;
        tick();
        chk_state("satu0", 12'h00F, 1'b1, 1'b1);
        tick();
        chk_state("satu1", 12'h00F, 1'b1, 1'b1);

        // Step clamped to limit: 3 + 5 = 8, modulo 6 -> 2
        do_load(12'd5, 12'd3);
        bus.up = 1'b1; bus.sat = 1'b0; bus.step = 12'd9; bus.enable = 1'b1;
        tick();
        chk_state("clamp", 12'd2, 1'b1, 1'b1);

        // Saturate down
        do_load(12'd5, 12'd1);
        bus.up = 1'b0; bus.sat = 1'b1; bus.step = 12'd3; bus.enable = 1'b1;
        tick();
        chk_state("satd", 12'd0, 1'b1, 1'b1);

        // Limit lowered below count: up goes to 0, then step 0 holds
        do_load(12'hFFF, 12'h050);
        bus.limit = 12'h010; bus.up = 1'b1; bus.sat = 1'b0; bus.step = 12'd1;
        bus.enable = 1'b1;
        tick();
        chk_state("oor.up", 12'h000, 1'b1, 1'b1);
        bus.step = 12'd0;
        tick();
        chk_state("step0", 12'h000, 1'b0, 1'b1);

        // Limit lowered below count: down goes to limit
        do_load(12'hFFF, 12'h050);
        bus.limit = 12'h010; bus.up = 1'b0; bus.step = 12'd1; bus.enable = 1'b1;
        tick();
        chk_state("oor.dn", 12'h010, 1'b1, 1'b1);

        // Reset mid-count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.enable = 1'b0;
        chk_state("rst2", 12'h000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_param.md
# counter_param

Parametrised up/down counter, the successor to the fixed 12-bit load/enable counter. It adds:
- configurable width and reset value;
- direction control;
- programmable step and inclusive upper limit;
- selectable wrap or saturate behaviour;
- boundary-event and sticky overflow flags.

It sits in the same datapath slot as the 12-bit counter: timebases, address generators and event counting. With `limit` at all-ones, `step = 1`, `up = 1` and `sat = 0`, it behaves as that counter.

## Interface
Parameters:
- `WIDTH`, 12, counter width in bits (≥ 2).
- `RESET_VAL`, 0, value of `counter` after reset; must be < 2^WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset; highest priority.
- `load`  in  1  load `data` into `counter`.
- `enable`  in  1  perform one count step this cycle.
- `up`  in  1  direction: 1 = up, 0 = down.
- `sat`  in  1  boundary mode: 0 = wrap (modulo limit+1), 1 = saturate.
- `step`  in  WIDTH  amount added or subtracted per count.
- `limit`  in  WIDTH  inclusive maximum count value.
- `data`  in  WIDTH  load value.
- `counter`  out  WIDTH  registered count.
- `wrap`  out  1  registered one-cycle pulse: the last count crossed a boundary (wrapped or clipped).
- `ovf`  out  1  registered sticky flag, set by any `wrap` event.
- `zero`  out  1  combinational: `counter == 0`.
- `at_limit`  out  1  combinational: `counter == limit`.

## Operation
**Priority per edge:** `reset` > `load` > `enable` > hold.

**Reset:**
- `counter` = `RESET_VAL`, `wrap` = 0, `ovf` = 0.

**Load:**
- `counter` = min(`data`, `limit`).
- `wrap` = 0 and `ovf` = 0 (load clears the sticky flag).
- `enable` is ignored that cycle; no count occurs.

**Effective step:** s = min(`step`, `limit`). `step` = 0 is legal: the counter holds and `wrap` stays 0.

**All arithmetic:** done in WIDTH+1 bits, with M = `limit` + 1. With `limit` at all-ones, M = 2^WIDTH, which needs no special case.

**Out-of-range count:** if `counter` > `limit` when a count occurs (only possible after `limit` is lowered), then:
- `counter` = 0 if `up`, `limit` if down;
- `wrap` pulses and `ovf` sets.

**Up count**, with sum = `counter` + s:
- sum ≤ `limit`: `counter` = sum, `wrap` = 0.
- sum > `limit`, `sat` = 0: `counter` = sum − M (always ≤ `limit`), `wrap` = 1.
- sum > `limit`, `sat` = 1: `counter` = `limit`, `wrap` = 1.

**Down count:**
- `counter` ≥ s: `counter` = `counter` − s, `wrap` = 0.
- `counter` < s, `sat` = 0: `counter` = `counter` + M − s, `wrap` = 1.
- `counter` < s, `sat` = 1: `counter` = 0, `wrap` = 1.

**Saturate mode:** `wrap` pulses on every clipped count, including repeated counts while pinned at the bound.

**Hold** (no reset, load or enable): `counter` and `ovf` keep their values; `wrap` = 0.

## Timing
- Latency is one cycle: the new `counter`, `wrap` and `ovf` appear together after the edge that samples the controls.
- `wrap` is high for exactly the cycle in which the post-boundary value is on `counter`.
- `ovf` rises in the same cycle as the first `wrap` pulse.
- `zero` and `at_limit` follow `counter` (and `limit`) combinationally, with no added latency.
- `up`, `sat`, `step` and `limit` are sampled on the same edge as `enable`. They may change every cycle; no pipeline state is held.
- Reset mid-count overrides a simultaneous `load` or `enable`.

## Test plan
All scenarios use `WIDTH` = 12 and `RESET_VAL` = 0.
1. **Reset dominance:** `reset` = 1, `load` = 1, `enable` = 1, `data` = 0xABC for 2 cycles -> `counter` = 0x000, `wrap` = 0, `ovf` = 0, `zero` = 1.
2. **Up wrap at full range:** `limit` = 0xFFF, `step` = 1, `up` = 1, `sat` = 0; load 0xFFE, then enable -> `counter` goes 0xFFE, 0xFFF, 0x000. `wrap` pulses only on 0x000; `ovf` = 1 afterwards.
3. **Load over enable:** while counting, `data` = 0x0F7 with `load` = 1 and `enable` = 1 -> next `counter` = 0x0F7, not 0x0F8; `ovf` cleared. Loading `data` = 0x020 with `limit` = 0x010 -> `counter` = 0x010.
4. **Modulo down wrap:** `limit` = 9, `step` = 3, `up` = 0, `sat` = 0, `counter` = 1 -> 8 with `wrap` = 1, then 5 with `wrap` = 0.
5. **Saturate and step clamp:**
   - `limit` = 0x00F, `step` = 4, `up` = 1, `sat` = 1, from 0x00C -> 0x00F with `wrap` = 1; the next count stays 0x00F with `wrap` = 1 again.
   - `limit` = 5, `step` = 9, `sat` = 0, from 3 -> 2 (s = 5).
6. **Limit lowered:** `counter` = 0x050, `limit` changed to 0x010, up count -> `counter` = 0x000, `wrap` = 1, `ovf` = 1. `step` = 0 with `enable` = 1 -> `counter` holds, `wrap` = 0.
